// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - round-robin arbiter with one-hot registered grant and grant-tenure limit
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        [N-1:0] request vector, bit i = requester i wants the resource
//   gnt        [N-1:0] registered one-hot grant, zero when idle
//   gnt_idx    [clog2(N)-1:0] index of the granted requester, zero when idle
//   gnt_valid  high while a grant is held (equals |gnt)
//   timeout    one-cycle pulse after a grant was revoked by the tenure limit

module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  ptr, ptr_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [N-1:0]   gnt_n;
    logic [IW-1:0]  idx_n;
    logic           valid_n;
    logic           timeout_n;

    logic           found;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  cand;

    // First set request bit starting at ptr; N is a power of two so the
    // IW-bit addition wraps modulo N by itself.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        idx_n     = gnt_idx;
        valid_n   = gnt_valid;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = BUSY;
                    gnt_n      = '0;
                    gnt_n[sel] = 1'b1;
                    idx_n      = sel;
                    valid_n    = 1'b1;
                    hold_n     = '0;
                end
            end
            BUSY: begin
                if (!req[gnt_idx] || (hold_cnt == HOLD_LAST)) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    idx_n     = '0;
                    valid_n   = 1'b0;
                    hold_n    = '0;
                    ptr_n     = gnt_idx + IW'(1);
                    // A simultaneous request drop counts as a normal release,
                    // so the pulse only fires when the owner still requests.
                    timeout_n = req[gnt_idx];
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - directed self-checking bench for rr_priority_arbiter

module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int errors;
    int checks;

    rr_priority_arbiter #(.N(8), .HOLD_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        tick();
        tick();
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h exp=%h", gnt, 8'h00); end
        checks++;
        if (gnt_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=%0d", gnt_idx, 0); end
        checks++;
        if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=%b", gnt_valid, 1'b0); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=%b", timeout, 1'b0); end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'h01) begin errors++; $display("FAIL first_gnt got=%h exp=%h", gnt, 8'h01); end
        checks++;
        if (gnt_idx !== 3'd0) begin errors++; $display("FAIL first_idx got=%0d exp=%0d", gnt_idx, 0); end
        checks++;
        if (gnt_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=%b", gnt_valid, 1'b1); end
    endtask

    // Entered with requester 0 granted and req=FF.
    task automatic test_round_robin();
        logic [7:0] exp_gnt;
        logic [2:0] exp_idx;
        for (int k = 0; k < 8; k++) begin
            exp_idx = 3'(k);
            exp_gnt = 8'h01 << k;
            req = 8'hFF & ~exp_gnt;
            tick();
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_%0d got gnt=%h valid=%b timeout=%b exp gnt=00 valid=0 timeout=0", k, gnt, gnt_valid, timeout);
            end
            req = 8'hFF;
            tick();
            exp_idx = exp_idx + 3'd1;
            exp_gnt = 8'h01 << exp_idx;
            checks++;
            if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant_%0d got gnt=%h idx=%0d valid=%b exp gnt=%h idx=%0d valid=1", k, gnt, gnt_idx, gnt_valid, exp_gnt, exp_idx);
            end
        end
    endtask

    task automatic test_wrap_skip();
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        req = 8'h20;
        tick();
        checks++;
        if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin errors++; $display("FAIL wrap_pre_idx got=%0d gnt=%h exp=5 gnt=20", gnt_idx, gnt); end
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL wrap_release got=%h exp=%h", gnt, 8'h00); end
        req = 8'h05;
        tick();
        checks++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin errors++; $display("FAIL wrap_idx got=%0d gnt=%h exp=0 gnt=01", gnt_idx, gnt); end
        req = 8'h04;
        tick();
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL skip_release got=%h exp=%h", gnt, 8'h00); end
        // Requester 0 asks again; ptr=1 must pick 2 ahead of it.
        req = 8'h05;
        tick();
        checks++;
        if (gnt_idx !== 3'd2 || gnt !== 8'h04) begin errors++; $display("FAIL skip_idx got=%0d gnt=%h exp=2 gnt=04", gnt_idx, gnt); end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h09;
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (gnt_idx !== 3'd0 || gnt !== 8'h01 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d got idx=%0d gnt=%h timeout=%b exp idx=0 gnt=01 timeout=0", c, gnt_idx, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got gnt=%h timeout=%b exp gnt=00 timeout=1", gnt, timeout); end
        tick();
        checks++;
        if (gnt_idx !== 3'd3 || gnt !== 8'h08 || timeout !== 1'b0) begin errors++; $display("FAIL after_timeout got idx=%0d gnt=%h timeout=%b exp idx=3 gnt=08 timeout=0", gnt_idx, gnt, timeout); end
    endtask

    // Entered with requester 3 granted on its first cycle, req=09.
    task automatic test_coincident();
        for (int c = 0; c < 15; c++) tick();
        checks++;
        if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin errors++; $display("FAIL coin_still_held got idx=%0d valid=%b exp idx=3 valid=1", gnt_idx, gnt_valid); end
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL coin_release got gnt=%h timeout=%b exp gnt=00 timeout=0", gnt, timeout); end
        tick();
        checks++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin errors++; $display("FAIL coin_next got idx=%0d gnt=%h exp idx=0 gnt=01", gnt_idx, gnt); end
        req = 8'h00;
        tick();
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h20;
        tick();
        checks++;
        if (gnt_idx !== 3'd5) begin errors++; $display("FAIL mid_pre_idx got=%0d exp=%0d", gnt_idx, 5); end
        req = 8'h30;
        tick();
        checks++;
        if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin errors++; $display("FAIL no_preempt got idx=%0d gnt=%h exp idx=5 gnt=20", gnt_idx, gnt); end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got gnt=%h idx=%0d valid=%b exp gnt=00 idx=0 valid=0", gnt, gnt_idx, gnt_valid); end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt_idx !== 3'd4 || gnt !== 8'h10) begin errors++; $display("FAIL post_reset got idx=%0d gnt=%h exp idx=4 gnt=10", gnt_idx, gnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_coincident();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
